xscore_display: RTL
===================

# xscore_display

Write-only picoversat bus responder behind the decoder's `score_sel` strobe. Accepts a binary score from the CPU, converts it to BCD with an iterative double-dabble engine, and time-multiplexes the digits onto a common-anode 7-segment display. It has no read path; the decoder returns 0 for reads at the score window.

## Interface
- `DIGITS`, 4: number of display digits; BCD width is 4·DIGITS.
- `SCORE_W`, 14: binary score width; 2^SCORE_W must cover 10^DIGITS − 1.
- `REFRESH_DIV`, 50000: clock cycles each digit stays lit.
- `clk`  in  1  system clock; everything runs in this single domain.
- `rst`  in  1  asynchronous, active-low reset.
- `sel`  in  1  score window select (`score_sel` from the address decoder).
- `we`  in  1  write enable; a register write occurs only when `sel` and `we` are both 1.
- `addr`  in  `SCORE_ADDR_W`  register offset; only bit 0 is decoded, bits above it are ignored.
- `data_in`  in  32  write data.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  DIGITS  digit enables, active-low, one-hot-low when lit.
- `busy`  out  1  conversion in progress.

## Operation
- Offset 0, SCORE: write latches `data_in[SCORE_W-1:0]` and starts a conversion.
  - Values above 10^DIGITS − 1 saturate to 10^DIGITS − 1 before conversion.
- Offset 1, CTRL:
  - `data_in[0]` = display enable; reset value 0.
  - `data_in[1]` = leading-zero blank; reset value 1.
- Converter FSM, states IDLE → SHIFT → COMMIT → IDLE:
  - IDLE: waits for a SCORE write.
  - SHIFT: exactly SCORE_W cycles; each cycle adds 3 to any BCD nibble ≥5, then shifts left by 1.
  - COMMIT: 1 cycle; copies the BCD result into the display register.
- A SCORE write while not IDLE aborts the conversion and restarts SHIFT with the new value; the latest write wins.
- A CTRL write takes effect the next cycle and does not disturb the FSM.
- The display register changes only in COMMIT, so the display never shows a partial result.
- Scan:
  - A counter runs 0..REFRESH_DIV−1. At terminal count, the digit index advances; it wraps from DIGITS−1 to 0.
  - Digit 0 is least significant.
  - `an[idx]` = 0 and `seg` = pattern of nibble idx.
- Blanking:
  - Enable = 0: `an` is all 1s and `seg` = 7'h7F.
  - Blank = 1: digits above the most-significant non-zero digit are dark (their `an` bit = 1). Digit 0 is always lit.
- Nibble values 10–15 cannot occur; they decode to 7'h7F.

## Timing
- Reset values:
  - `seg` = 7'h7F, `an` = all 1s, `busy` = 0.
  - Display register = 0, digit index = 0, refresh counter = 0, FSM = IDLE.
- SCORE write sampled on edge t:
  - `busy` = 1 from t+1 through t+SCORE_W+1.
  - New digits are visible from t+SCORE_W+2 (16 cycles with the defaults).
  - `busy` = 0 at t+SCORE_W+2.
- `seg` and `an` are registered: 1-cycle latency from index or data change.
- Reset mid-conversion: the conversion is discarded and the display returns to 0 and dark.
- Back-to-back SCORE writes on consecutive cycles: only the last value commits; `busy` stays 1 throughout.
- Writes with `sel` = 0 or `we` = 0 are ignored.

## Structure
- Add to `xdefs.vh`:
  - `SCORE_ADDR_W` (1) and `SCORE_BASE`.
  - Offsets `SCORE_VAL` = 0 and `SCORE_CTRL` = 1.
- Sub-module `xbin2bcd`:
  - Parameterised SCORE_W and DIGITS.
  - Ports: start, bin, busy, done pulse, bcd.
  - Contains the SHIFT FSM.
- The top level holds the register write logic, saturation, display register, scan counter, blanking and 7-segment decode.

## Test plan
- After reset release, write CTRL = 3 then SCORE = 1234 → `busy` high for 15 cycles; digits then scan as `an` = 1110/1101/1011/0111 with `seg` for 4, 3, 2, 1; each digit lit for REFRESH_DIV cycles.
- SCORE = 7 with blank = 1 → only `an` = 1110 lit, showing 7; with CTRL = 1 (blank off) → 0007 shown.
- SCORE = 12000 → saturates; 9999 displayed.
- SCORE = 5555, then SCORE = 42 three cycles later → 5555 never appears; 42 commits 16 cycles after the second write.
- Drop `rst` low mid-SHIFT → `busy` = 0, `an` = 1111 and `seg` = 7'h7F immediately, without waiting for a clock edge.
- CTRL = 0 while 1234 is displayed → `an` = 1111 next cycle; CTRL = 3 restores 1234 with no re-conversion.

Source files
------------

// File: rtl/xscore_display_pkg.sv
// -----------------------------------------------------------------------------
// xscore_display_pkg
// Shared definitions for the score display responder:
//   - bus window constants (address width, base, register offsets)
//   - converter FSM state encoding
//   - helpers: power of ten, 7-segment decode (active-low {g,f,e,d,c,b,a})
// -----------------------------------------------------------------------------
package xscore_display_pkg;

    // Address window of the score responder as seen by the picoversat decoder
    localparam int                      SCORE_ADDR_W = 1;
    localparam logic [31:0]             SCORE_BASE   = 32'h0000_0100;

    // Register offsets inside the window (only bit 0 is decoded)
    localparam logic [SCORE_ADDR_W-1:0] SCORE_VAL    = 1'b0;
    localparam logic [SCORE_ADDR_W-1:0] SCORE_CTRL   = 1'b1;

    // All segments dark (active-low)
    localparam logic [6:0]              SEG_OFF      = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } bcd_state_t;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < n; i++) begin
            v = v * 10;
        end
        return v;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles are dark
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/xscore_display_xbin2bcd.sv
// -----------------------------------------------------------------------------
// xbin2bcd
// Iterative double-dabble binary-to-BCD converter.
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for start
//   ST_SHIFT  | one add-3/shift step per cycle, SCORE_W cycles in total
//   ST_COMMIT | bcd holds the final result for one cycle, done = 1
//
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   start  in   load bin and (re)start a conversion; wins in any state
//   bin    in   SCORE_W-bit binary value
//   busy   out  conversion in progress (SHIFT or COMMIT)
//   done   out  high during COMMIT, bcd is valid
//   bcd    out  4*DIGITS-bit packed BCD, digit 0 in the low nibble
// -----------------------------------------------------------------------------
module xbin2bcd
    import xscore_display_pkg::*;
#(
    parameter int SCORE_W = 14,
    parameter int DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

    bcd_state_t          r_state;
    logic [SCORE_W-1:0]  r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [BCD_W-1:0]    w_adj;

    // Add 3 to every nibble >= 5 before the shift
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (start) begin
            // A new start discards any conversion in flight
            r_state <= ST_SHIFT;
            r_bin   <= bin;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(SCORE_W - 1);
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    r_bcd <= {w_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
                    r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        r_state <= ST_COMMIT;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: rtl/xscore_display.sv
// -----------------------------------------------------------------------------
// xscore_display
// Write-only picoversat bus responder: takes a binary score, converts it to
// BCD and time-multiplexes the digits onto a common-anode 7-segment display.
//
// Registers (offset = addr[0])
//   0 SCORE : write data_in[SCORE_W-1:0], saturated to 10^DIGITS-1, starts a
//             conversion
//   1 CTRL  : bit 0 display enable (reset 0), bit 1 leading-zero blank (reset 1)
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   sel      in   score window select from the address decoder
//   we       in   write enable (write = sel & we)
//   addr     in   register offset
//   data_in  in   write data
//   seg      out  active-low segments {g,f,e,d,c,b,a}, registered
//   an       out  active-low digit enables, registered
//   busy     out  conversion in progress
// -----------------------------------------------------------------------------
module xscore_display
    import xscore_display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SCORE_W     = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel,
    input  logic                    we,
    input  logic [SCORE_ADDR_W-1:0] addr,
    input  logic [31:0]             data_in,
    output logic [6:0]              seg,
    output logic [DIGITS-1:0]       an,
    output logic                    busy
);

    localparam int                 BCD_W     = 4 * DIGITS;
    localparam int                 IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int                 DIV_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(pow10(DIGITS) - 1);

    logic                 w_score_wr;
    logic                 w_ctrl_wr;
    logic [SCORE_W-1:0]   w_score_sat;
    logic                 w_bcd_busy;
    logic                 w_bcd_done;
    logic [BCD_W-1:0]     w_bcd;
    logic [IDX_W-1:0]     w_msd;
    logic                 w_lit;
    logic [3:0]           w_nib;
    logic                 w_unused_data;

    logic                 r_en;
    logic                 r_blank;
    logic [BCD_W-1:0]     r_disp;
    logic [DIV_W-1:0]     r_div;
    logic [IDX_W-1:0]     r_idx;
    logic [6:0]           r_seg;
    logic [DIGITS-1:0]    r_an;

    // ---------------- bus decode and saturation ----------------
    assign w_score_wr  = sel & we & (addr[0] == SCORE_VAL[0]);
    assign w_ctrl_wr   = sel & we & (addr[0] == SCORE_CTRL[0]);
    assign w_score_sat = (data_in[SCORE_W-1:0] > MAX_SCORE) ? MAX_SCORE
                                                             : data_in[SCORE_W-1:0];
    assign w_unused_data = ^data_in[31:SCORE_W];

    xbin2bcd #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_score_wr),
        .bin   (w_score_sat),
        .busy  (w_bcd_busy),
        .done  (w_bcd_done),
        .bcd   (w_bcd)
    );

    assign busy = w_bcd_busy;

    // ---------------- control and display registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en    <= 1'b0;
            r_blank <= 1'b1;
        end else if (w_ctrl_wr) begin
            r_en    <= data_in[0];
            r_blank <= data_in[1];
        end
    end

    // A SCORE write landing on the COMMIT cycle aborts that result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp <= '0;
        end else if (w_bcd_done && !w_score_wr) begin
            r_disp <= w_bcd;
        end
    end

    // ---------------- scan counter ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_W'(REFRESH_DIV - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // ---------------- blanking ----------------
    // Index of the most significant non-zero digit; 0 when the value is 0
    always_comb begin
        w_msd = '0;
        for (int d = 1; d < DIGITS; d++) begin
            if (r_disp[4*d +: 4] != 4'd0) begin
                w_msd = IDX_W'(d);
            end
        end
    end

    assign w_nib = r_disp[4*r_idx +: 4];
    assign w_lit = r_en && (!r_blank || (r_idx <= w_msd));

    // ---------------- registered display outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg <= SEG_OFF;
            r_an  <= '1;
        end else if (w_lit) begin
            r_seg <= seg_decode(w_nib);
            r_an  <= ~(DIGITS'(1) << r_idx);
        end else begin
            r_seg <= SEG_OFF;
            r_an  <= '1;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
